spi_byte_master: RTL and testbench
==================================

# spi_byte_master

SPI mode-0 byte transceiver that drives the flash pins (sck, cs, sdo, sdi) on behalf of a command sequencer such as the JEDEC-ID reader. The sequencer presents one byte per start pulse and receives the byte shifted in from the flash on done. Chip select can be held low across consecutive bytes, so multi-byte commands (0x9F plus 3 ID bytes) run as one transaction. Sits between the sequencer and the top-level pins, in ../lib next to led_driver.

## Interface
- CLK_DIV, 6, sck half-period in clk12MHz cycles (1 MHz sck at default); legal range 1..255.
- clk12MHz  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to transfer tx_byte; accepted only when busy=0.
- tx_byte  input  8  byte to send, MSB first; sampled on the accepted start edge.
- keep_cs  input  1  sampled at accepted start: 1 = leave cs low after this byte; level-checked in HOLD (0 = end transaction).
- busy  output  1  high while a byte or CS lead/trail phase is in progress.
- done  output  1  one-cycle pulse when rx_byte is updated.
- rx_byte  output  8  last received byte, MSB first; stable between done pulses.
- sck  output  1  SPI clock, idle low (CPOL=0).
- cs  output  1  chip select, active low.
- sdo  output  1  master-out data.
- sdi  input  1  master-in data.

## Operation
- States: IDLE, CS_LEAD, SCK_LO, SCK_HI, HOLD, CS_TRAIL.
- IDLE: cs=1, sck=0, busy=0. start → latch tx_byte/keep_cs, cs=0, sdo=tx_byte[7], go CS_LEAD.
- CS_LEAD: CLK_DIV cycles, then SCK_LO for bit 7.
- SCK_LO: sck=0 for CLK_DIV cycles, sdo holds current bit; then sck=1, sample sdi into shift register LSB (MSB-first shift), go SCK_HI.
- SCK_HI: sck=1 for CLK_DIV cycles; then sck=0; if bit 0 done: rx_byte ← shift reg, done=1, go HOLD (keep_cs=1) or CS_TRAIL (keep_cs=0); else sdo ← next bit, SCK_LO.
- HOLD: cs=0, sck=0, busy=0. start has priority: latch, sdo=tx_byte[7], go SCK_LO directly (no lead). Else if keep_cs=0 → CS_TRAIL.
- CS_TRAIL: cs=0 for CLK_DIV cycles, then cs=1, IDLE.
- start while busy=1: ignored, no state change, no latch.
- Bit counter 3 bits, counts 7→0; half-period counter 8 bits, reload CLK_DIV-1, no wrap beyond.

## Timing
- Reset values: cs=1, sck=0, sdo=0, busy=0, done=0, rx_byte=8'h00, state IDLE. rst mid-transfer: next edge returns to reset values, no done pulse, partial data discarded.
- busy rises the cycle after the accepted start edge.
- From IDLE: done asserted 17·CLK_DIV+1 cycles after start edge (103 at default). From HOLD: 16·CLK_DIV+1 (97).
- done and busy=0 (HOLD) or the CS_TRAIL phase begin on the same edge; start may be accepted in the cycle done is high when entering HOLD.
- sdo changes only on sck falling edge or at CS/HOLD entry; sdi sampled on sck rising edge. sdo setup before rising = CLK_DIV cycles.
- cs high → low to first sck rising: 2·CLK_DIV cycles; last sck falling → cs high: CLK_DIV cycles.

## Structure
- Shared header spi_defs.vh (../lib): state encodings, SPI command constants (CMD_RDID=8'h9F).
- Optional sub-module spi_half_tick: loadable down-counter emitting a tick every CLK_DIV cycles; otherwise inline.
- No FIFOs; single-byte buffer only.

## Test plan
- Single byte: tx 0x9F, keep_cs=0, slave model returns 0xEF → sdo bits 1,0,0,1,1,1,1,1 at rising edges; rx_byte=0xEF; done at cycle 103; cs high 6 cycles after last fall.
- Burst: 0x9F (keep_cs=1), then 0x00 ×3 with slave EF 40 18, keep_cs=0 on last → cs low continuously, rx sequence EF,40,18, gaps have no CS_LEAD.
- start pulsed mid-byte with tx 0x55 → ignored; rx/sdo of current byte unaffected.
- rst asserted at bit 4 → next cycle cs=1, sck=0, busy=0, no done; fresh start works normally.
- CLK_DIV=1: tx 0xA5, loopback sdo→sdi → rx_byte=0xA5, done at cycle 18.
- HOLD with keep_cs dropped and no start → CS_TRAIL, cs high after CLK_DIV cycles, IDLE.

Source files
------------

// File: rtl/spi_byte_master_pkg.sv
// Shared types and constants for the SPI mode-0 byte master and its command sequencers.
package spi_byte_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCsLead,
        StSckLo,
        StSckHi,
        StHold,
        StCsTrail
    } state_e;

    localparam logic [7:0] CmdRdid = 8'h9F;

    // HOLD counts as not busy so the sequencer can chain the next byte.
    function automatic logic is_busy(input state_e s);
        return !((s == StIdle) || (s == StHold));
    endfunction

endpackage

// File: rtl/spi_byte_master_if.sv
// Sequencer handshake plus flash pins; master modport is the transceiver side.
interface spi_byte_master_if;

    logic       start;
    logic [7:0] tx_byte;
    logic       keep_cs;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;
    logic       sck;
    logic       cs;
    logic       sdo;
    logic       sdi;

    modport master (
        input  start, tx_byte, keep_cs, sdi,
        output busy, done, rx_byte, sck, cs, sdo
    );

    modport slave (
        output start, tx_byte, keep_cs, sdi,
        input  busy, done, rx_byte, sck, cs, sdo
    );

endinterface

// File: rtl/spi_byte_master_half_tick.sv
// Loadable down-counter; tick_o is high once CLK_DIV cycles have elapsed since the last load.
module spi_byte_master_half_tick #(
    parameter int unsigned CLK_DIV = 6
) (
    input  logic clk12MHz,
    input  logic rst,
    input  logic load_i,
    output logic tick_o
);

    localparam logic [7:0] Reload = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = Reload;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            cnt_q <= Reload;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte transceiver; cs may be held low across bytes for multi-byte commands.
module spi_byte_master
    import spi_byte_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 6
) (
    input logic               clk12MHz,
    input logic               rst,
    spi_byte_master_if.master bus
);

    state_e     state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] rx_q, rx_d;
    logic [2:0] bit_q, bit_d, bit_nxt;
    logic       keep_q, keep_d;
    logic       sdo_q, sdo_d;
    logic       done_q, done_d;
    logic       tick;
    logic       accept;

    // Every state change restarts the half-period count.
    spi_byte_master_half_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_half_tick (
        .clk12MHz(clk12MHz),
        .rst     (rst),
        .load_i  (state_d != state_q),
        .tick_o  (tick)
    );

    assign accept = bus.start && ((state_q == StIdle) || (state_q == StHold));

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        keep_d  = keep_q;
        sdo_d   = sdo_q;
        done_d  = 1'b0;
        bit_nxt = bit_q - 3'd1;

        if (accept) begin
            tx_d   = bus.tx_byte;
            keep_d = bus.keep_cs;
            sdo_d  = bus.tx_byte[7];
            bit_d  = 3'd7;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StCsLead;
            end
            StCsLead: begin
                if (tick) state_d = StSckLo;
            end
            StSckLo: begin
                if (tick) begin
                    sh_d    = {sh_q[6:0], bus.sdi};
                    state_d = StSckHi;
                end
            end
            StSckHi: begin
                if (tick) begin
                    if (bit_q == 3'd0) begin
                        rx_d    = sh_q;
                        done_d  = 1'b1;
                        state_d = keep_q ? StHold : StCsTrail;
                    end else begin
                        bit_d   = bit_nxt;
                        sdo_d   = tx_q[bit_nxt];
                        state_d = StSckLo;
                    end
                end
            end
            StHold: begin
                if (accept) begin
                    state_d = StSckLo;
                end else if (!bus.keep_cs) begin
                    state_d = StCsTrail;
                end
            end
            StCsTrail: begin
                if (tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            state_q <= StIdle;
            tx_q    <= 8'h00;
            sh_q    <= 8'h00;
            rx_q    <= 8'h00;
            bit_q   <= 3'd7;
            keep_q  <= 1'b0;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            keep_q  <= keep_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = is_busy(state_q);
    assign bus.cs      = (state_q == StIdle);
    assign bus.sck     = (state_q == StSckHi);
    assign bus.sdo     = sdo_q;
    assign bus.done    = done_q;
    assign bus.rx_byte = rx_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Randomised bench for spi_byte_master: slave model on the pins, latency/data reference model.
module tb_spi_byte_master;
    import spi_byte_master_pkg::*;

    localparam int unsigned D6 = 6;
    localparam int unsigned D1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_byte_master_if bus6 ();
    spi_byte_master_if bus1 ();

    spi_byte_master #(.CLK_DIV(D6)) dut6 (
        .clk12MHz(clk),
        .rst     (rst),
        .bus     (bus6.master)
    );

    spi_byte_master #(.CLK_DIV(D1)) dut1 (
        .clk12MHz(clk),
        .rst     (rst),
        .bus     (bus1.master)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Flash model: shifts slave_byte out MSB first, advancing on sck falls; cs high rewinds.
    logic [7:0]  slave_byte = 8'h00;
    logic [2:0]  fall_cnt   = 3'd0;
    logic [7:0]  mosi_sh    = 8'h00;
    logic [2:0]  mosi_cnt   = 3'd0;
    logic [7:0]  mosi_q[$];
    int unsigned cs_rises   = 0;

    always @(negedge bus6.sck or posedge bus6.cs) begin
        if (bus6.cs) fall_cnt <= 3'd0;
        else         fall_cnt <= fall_cnt + 3'd1;
    end

    always @(posedge bus6.sck or posedge bus6.cs) begin
        if (bus6.cs) begin
            mosi_cnt <= 3'd0;
        end else begin
            mosi_sh  <= {mosi_sh[6:0], bus6.sdo};
            mosi_cnt <= mosi_cnt + 3'd1;
            if (mosi_cnt == 3'd7) mosi_q.push_back({mosi_sh[6:0], bus6.sdo});
        end
    end

    always @(posedge bus6.cs) cs_rises <= cs_rises + 1;

    assign bus6.sdi = slave_byte[3'd7 - fall_cnt];
    assign bus1.sdi = bus1.sdo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One byte on the CLK_DIV=6 master; optionally pulses a stray start at cycle inject_at.
    task automatic xfer6(input logic [7:0] tx, input logic kp, input logic [7:0] sb,
                         input bit from_hold, input int inject_at);
        int n;
        @(negedge clk);
        slave_byte    = sb;
        bus6.start    = 1'b1;
        bus6.tx_byte  = tx;
        bus6.keep_cs  = kp;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            bus6.start = (n == inject_at);
            if (n == inject_at) begin
                bus6.tx_byte = 8'h55;
                bus6.keep_cs = ~kp;
            end else begin
                bus6.keep_cs = kp;
            end
            if (n == 1) check("busy_rise", {31'd0, bus6.busy}, 32'd1);
            if (bus6.done === 1'b1) break;
        end
        check("done_latency", n, from_hold ? 16 * D6 + 1 : 17 * D6 + 1);
        check("rx_byte", {24'd0, bus6.rx_byte}, {24'd0, sb});
        check("busy_at_done", {31'd0, bus6.busy}, kp ? 32'd0 : 32'd1);
        check("cs_low_at_done", {31'd0, bus6.cs}, 32'd0);
        check("mosi_count", mosi_q.size(), 32'd1);
        if (mosi_q.size() > 0) check("mosi_byte", {24'd0, mosi_q.pop_front()}, {24'd0, tx});
    endtask

    task automatic trail6(input int exp);
        int n;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check("done_pulse", {31'd0, bus6.done}, 32'd0);
            if (bus6.cs === 1'b1) break;
        end
        check("cs_trail", n, exp);
        check("idle_busy", {31'd0, bus6.busy}, 32'd0);
    endtask

    task automatic drop_keep6();
        @(negedge clk);
        bus6.keep_cs = 1'b0;
        trail6(D6 + 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  tx, sb;
        logic        kp, prev_kp;
        int unsigned c0;
        int          n, dones;

        bus6.start = 1'b0; bus6.tx_byte = 8'h00; bus6.keep_cs = 1'b0;
        bus1.start = 1'b0; bus1.tx_byte = 8'h00; bus1.keep_cs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {31'd0, bus6.cs}, 32'd1);
        check("rst_sck", {31'd0, bus6.sck}, 32'd0);
        check("rst_sdo", {31'd0, bus6.sdo}, 32'd0);
        check("rst_busy", {31'd0, bus6.busy}, 32'd0);
        check("rst_done", {31'd0, bus6.done}, 32'd0);
        check("rst_rx", {24'd0, bus6.rx_byte}, 32'd0);
        check("rst_cs1", {31'd0, bus1.cs}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single RDID byte, flash answers 0xEF.
        xfer6(CmdRdid, 1'b0, 8'hEF, 1'b0, 0);
        trail6(D6);

        // JEDEC-ID burst: cs must stay low across all four bytes.
        c0 = cs_rises;
        xfer6(CmdRdid, 1'b1, 8'($urandom), 1'b0, 0);
        xfer6(8'h00, 1'b1, 8'hEF, 1'b1, 0);
        xfer6(8'h00, 1'b1, 8'h40, 1'b1, 0);
        xfer6(8'h00, 1'b0, 8'h18, 1'b1, 0);
        trail6(D6);
        check("burst_cs_rises", cs_rises - c0, 32'd1);

        // Stray start mid-byte must not disturb the byte in flight.
        xfer6(8'hA3, 1'b0, 8'h3C, 1'b0, 40);
        trail6(D6);

        // Reset around bit 4.
        @(negedge clk);
        slave_byte = 8'h5A; bus6.start = 1'b1; bus6.tx_byte = 8'hC3; bus6.keep_cs = 1'b0;
        @(posedge clk);
        #1;
        bus6.start = 1'b0;
        repeat (8 * D6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_cs", {31'd0, bus6.cs}, 32'd1);
        check("mid_rst_sck", {31'd0, bus6.sck}, 32'd0);
        check("mid_rst_busy", {31'd0, bus6.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus6.done}, 32'd0);
        check("mid_rst_rx", {24'd0, bus6.rx_byte}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20 * D6; i++) begin
            @(posedge clk);
            #1;
            if (bus6.done === 1'b1) dones++;
        end
        check("mid_rst_no_done", dones, 32'd0);
        check("mid_rst_discard", mosi_q.size(), 32'd0);
        xfer6(8'h96, 1'b0, 8'h69, 1'b0, 0);
        trail6(D6);

        // HOLD then keep_cs dropped with no further start.
        xfer6(8'h12, 1'b1, 8'h34, 1'b0, 0);
        drop_keep6();

        // Random bytes with random chaining.
        prev_kp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx = 8'($urandom);
            sb = 8'($urandom);
            kp = 1'($urandom_range(0, 1));
            xfer6(tx, kp, sb, prev_kp, 0);
            if (!kp) trail6(D6);
            prev_kp = kp;
        end
        if (prev_kp) drop_keep6();

        // CLK_DIV=1 with sdo looped back to sdi.
        for (int i = 0; i < 4; i++) begin
            tx = (i == 0) ? 8'hA5 : 8'($urandom);
            @(negedge clk);
            bus1.start = 1'b1; bus1.tx_byte = tx; bus1.keep_cs = 1'b0;
            n = 0;
            while (n < 100) begin
                @(posedge clk);
                #1;
                n++;
                bus1.start = 1'b0;
                if (bus1.done === 1'b1) break;
            end
            check("div1_latency", n, 17 * D1 + 1);
            check("div1_rx", {24'd0, bus1.rx_byte}, {24'd0, tx});
            n = 0;
            while (n < 100) begin
                @(posedge clk);
                #1;
                n++;
                if (bus1.cs === 1'b1) break;
            end
            check("div1_trail", n, D1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
